// File: rtl/uart_pkg.sv
// Frame constants and receiver state encoding shared by the UART transmitter and receiver.
package uart_pkg;

  localparam int UART_NBITS = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to the line idle level by default.
module uart_sync
  import uart_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{UART_IDLE_LEVEL}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop decoding with framing-error and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int NBITS      = UART_NBITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             tick,
  input  logic             Rx,
  output logic [NBITS-1:0] RxData,
  output logic             RxDone,
  output logic             RxErr,
  output logic             RxBusy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  logic rxSync;

  uart_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  uart_sync #(.WIDTH(1)) rxSyncInst (
    .Clk    (Clk),
    .Rst    (Rst),
    .async_i(Rx),
    .sync_o (rxSync)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Everything holds between ticks; only the one-cycle pulses fall back to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rxSync) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rxSync ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d = NBITS'({rxSync, shift_q} >> 1);
            cnt_d   = '0;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxSync) begin
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = BRK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        BRK: begin
          if (rxSync) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign RxData = data_q;
  assign RxDone = done_q;
  assign RxErr  = err_q;
  assign RxBusy = (state_q != IDLE);

endmodule
